// File: rtl/wphy_pam4_rx_des.sv
// wphy_pam4_rx_des: PAM4/NRZ slicer deserializer with bitslip; WPHY_PAM4_GRAY_DEC_EN enables Gray decode of PAM4 symbols.
module wphy_pam4_rx_des #(
  parameter int NSYM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              pam4_en,
  input  logic [1:0]        din,
  input  logic              bitslip,
  output logic [2*NSYM-1:0] dout,
  output logic              dout_valid,
  output logic              slip_pend
);
  localparam int W = 2 * NSYM;
  localparam int CW = $clog2(W);
  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;
  logic [W-1:0]  sr;
  logic [W-1:0]  sr_nxt;
  logic [1:0]    sym;
  logic          mode_q;
  logic          chg;
  logic          cap;
  logic          last;
`ifdef WPHY_PAM4_GRAY_DEC_EN
  assign sym = {din[1], din[1] ^ din[0]};
`else
  assign sym = din;
`endif
  // Symbols enter at the top and shift down, so the first one ends at the LSB.
  always_comb begin
    chg    = pam4_en != mode_q;
    cap    = ena && !chg && !slip_pend;
    lim    = pam4_en ? CW'(NSYM - 1) : CW'(W - 1);
    last   = cap && cnt == lim;
    sr_nxt = pam4_en ? {sym, sr[W-1:2]} : {din[1], sr[W-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      sr         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      slip_pend  <= 1'b0;
      mode_q     <= pam4_en;
    end else begin
      dout_valid <= last;
      if (last) dout <= sr_nxt;
      if (ena) begin
        mode_q <= pam4_en;
        if (chg) begin
          cnt       <= '0;
          sr        <= '0;
          slip_pend <= 1'b0;
        end else if (slip_pend) begin
          slip_pend <= 1'b0;
        end else begin
          sr        <= sr_nxt;
          cnt       <= last ? '0 : cnt + CW'(1);
          slip_pend <= bitslip;
        end
      end
    end
  end
endmodule

// File: tb/tb_wphy_pam4_rx_des.sv
// tb_wphy_pam4_rx_des: directed vectors with a queue scoreboard checked by a dout_valid monitor.
module tb_wphy_pam4_rx_des;
  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        pam4_en;
  logic [1:0]  din;
  logic        bitslip;
  logic [15:0] dout;
  logic        dout_valid;
  logic        slip_pend;
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
`ifdef WPHY_PAM4_GRAY_DEC_EN
  localparam logic [15:0] W4 = 16'hB4B4, W1 = 16'h2DB4, W2 = 16'h2D2D, WF = 16'hAAAA, WA = 16'hFFFF;
`else
  localparam logic [15:0] W4 = 16'hE4E4, W1 = 16'h39E4, W2 = 16'h3939, WF = 16'hFFFF, WA = 16'hAAAA;
`endif
  wphy_pam4_rx_des #(.NSYM(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pam4_en(pam4_en), .din(din),
    .bitslip(bitslip), .dout(dout), .dout_valid(dout_valid), .slip_pend(slip_pend)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic e, input logic [1:0] d, input logic b);
    ena = e;
    din = d;
    bitslip = b;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got dout %h expected no strobe", dout);
      end else chk("word", 32'(dout), 32'(exp_q.pop_front()));
    end
  end
  initial begin
    rst = 1'b1;
    ena = 1'b1;
    pam4_en = 1'b1;
    din = 2'b11;
    bitslip = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_slip", 32'(slip_pend), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(W4);
      cyc(1'b1, 2'(i % 4), 1'b0);
    end
    chk("pam4_latency", 32'(dout_valid), 1);
    pam4_en = 1'b0;
    cyc(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(16'h5555);
      cyc(1'b1, {~i[0], 1'($urandom)}, 1'b0);
    end
    chk("nrz_latency", 32'(dout_valid), 1);
    pam4_en = 1'b1;
    cyc(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 17; i++) begin
      if (i == 8) exp_q.push_back(W1);
      if (i == 16) exp_q.push_back(W2);
      cyc(1'b1, 2'(i % 4), i == 3 || i == 4);
      if (i == 3) chk("slip_set", 32'(slip_pend), 1);
      if (i == 4) chk("slip_clr", 32'(slip_pend), 0);
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'b11, 1'b0);
    pam4_en = 1'b0;
    cyc(1'b1, 2'b10, 1'b0);
    chk("toggle_no_valid", 32'(dout_valid), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(16'h00FF);
      cyc(1'b1, {1'(i < 8), 1'b1}, 1'b0);
    end
    pam4_en = 1'b1;
    cyc(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b01, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 2'b10, 1'b1);
    chk("midrst_dout", 32'(dout), 0);
    chk("midrst_valid", 32'(dout_valid), 0);
    chk("midrst_slip", 32'(slip_pend), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) repeat (3) cyc(1'b0, 2'b11, 1'b1);
      if (i == 7) exp_q.push_back(W4);
      cyc(1'b1, 2'(i % 4), 1'b0);
    end
    chk("stall_slip", 32'(slip_pend), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(WF);
      cyc(1'b1, 2'b11, i == 7);
    end
    chk("slip_on_last", 32'(slip_pend), 1);
    cyc(1'b1, 2'b01, 1'b0);
    chk("slip_after_last", 32'(slip_pend), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(WA);
      cyc(1'b1, 2'b10, 1'b0);
    end
    repeat (3) cyc(1'b0, 2'b00, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wphy_pam4_rx_des.md
WPHY_PAM4_RX_DES -- requirements
Module: wphy_pam4_rx_des

Interface
REQ-001 SHALL have parameter NSYM, default 8, meaning symbols per output word in PAM4 mode (legal 2..32, even).
REQ-002 SHALL have port clk, input, 1, sampling clock (same clock that strobes the PAM4 slicer).
REQ-003 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL have port ena, input, 1, capture enable; 0 freezes all state except reset.
REQ-005 SHALL have port pam4_en, input, 1, 1 = PAM4 (2 bits/symbol), 0 = NRZ (1 bit/cycle, taken from din[1]).
REQ-006 SHALL have port din, input, 2, slicer decision per clk (din[1] = MSB comparator, din[0] = LSB decode).
REQ-007 SHALL have port bitslip, input, 1, single-cycle request to shift the word boundary by one symbol.
REQ-008 SHALL have port dout, output, 2*NSYM, assembled word.
REQ-009 SHALL have port dout_valid, output, 1, one-cycle strobe qualifying dout.
REQ-010 SHALL have port slip_pend, output, 1, high while an accepted bitslip is not yet applied.

Function
REQ-011 SHALL capture one symbol per clk when ena=1 into an internal shift register; first-received symbol lands in the least-significant position.
REQ-012 PAM4 mode: each capture SHALL append 2 bits {b1,b0}; a word completes after NSYM captures.
REQ-013 NRZ mode: each capture SHALL append din[1] only; a word completes after 2*NSYM captures; din[0] SHALL be ignored.
REQ-014 Capture counter SHALL count 0..(limit-1) and wrap to 0 on the completing capture; no capture ever spans two words.
REQ-015 On the completing capture, dout SHALL load the full word and dout_valid SHALL be 1 in the following cycle (latency 1 clk from last symbol); otherwise dout_valid=0 and dout holds its last value.
REQ-016 bitslip=1 while slip_pend=0 and ena=1 SHALL set slip_pend; the next enabled capture SHALL be discarded (no shift, no count) and slip_pend SHALL clear in that cycle.
REQ-017 bitslip while slip_pend=1 SHALL be ignored (no queuing); bitslip while ena=0 SHALL be ignored.
REQ-018 bitslip asserted in the same cycle as a completing capture: the word SHALL complete normally and the slip SHALL apply to the next capture.
REQ-019 Any change of pam4_en (registered previous value differs) SHALL clear counter, shift register and slip_pend in that cycle; that cycle's symbol SHALL be discarded and no dout_valid SHALL be produced for the partial word.
REQ-020 ena deasserted mid-word SHALL hold counter and partial word; capture SHALL resume on ena=1 without loss.

Reset
REQ-021 rst=1 at a clk edge SHALL force dout=0, dout_valid=0, slip_pend=0, counter=0, shift register=0, registered pam4_en copy = current pam4_en.
REQ-022 rst SHALL override ena, bitslip and mode change in the same cycle; the first capture SHALL occur on the first enabled edge after rst falls.

Configuration
REQ-023 Macro WPHY_PAM4_GRAY_DEC_EN defined: in PAM4 mode each symbol SHALL be Gray-decoded before packing, b1=din[1], b0=din[1]^din[0].
REQ-024 Macro WPHY_PAM4_GRAY_DEC_EN undefined: symbols SHALL be packed raw, b1=din[1], b0=din[0]; NRZ mode is unaffected either way.

Verification
REQ-025 NSYM=8, PAM4, macro off, din=2'b00,01,10,11 repeated x2 -> one dout_valid, dout=16'hE4E4, one clk after 8th symbol.
REQ-026 Same stimulus, macro on -> dout=16'hB4B4 (01->01, 10->11, 11->10).
REQ-027 NRZ, din[1]=1,0 alternating, din[0] random, 16 captures -> dout=16'h5555, dout_valid once.
REQ-028 PAM4, bitslip pulsed before symbol 0 of stream 00,01,10,11,... -> slip_pend high 1 cycle, symbol 00 dropped, first word=16'h39E4 ... then aligned words shifted by one symbol; second bitslip during slip_pend -> no extra drop.
REQ-029 Toggle pam4_en after 5 symbols -> no dout_valid for partial word; next word completes after full NSYM (or 2*NSYM) fresh captures.
REQ-030 rst asserted mid-word with ena=1, bitslip=1 -> next cycle all outputs 0, slip_pend=0; ena low for 3 cycles mid-word -> word identical to unstalled run.
